// File: rtl/seq_player_if.sv
// Player-side signal bundle: pushbuttons and ROM data toward the player,
// ROM address, step index and frequency word back out.
interface seq_player_if;
  logic       KEY0;
  logic       KEY1;
  logic       KEY2;
  logic       KEY3;
  logic [7:0] rom_data;
  logic [6:0] rom_addr;
  logic [6:0] seq_num;
  logic [7:0] freq_num;
  logic       freq_valid;
  logic       playing;

  modport master (
    input  KEY0, KEY1, KEY2, KEY3, rom_data,
    output rom_addr, seq_num, freq_num, freq_valid, playing
  );

  modport slave (
    output KEY0, KEY1, KEY2, KEY3, rom_data,
    input  rom_addr, seq_num, freq_num, freq_valid, playing
  );
endinterface

// File: rtl/seq_player.sv
// Step sequencer: debounced play/stop/step keys drive an IDLE/PLAY/PAUSE FSM
// whose step indexes an external ROM; each new step reloads freq_num.
module seq_player #(
  parameter int TICK_DIV  = 12500000,
  parameter int NUM_STEPS = 16,
  parameter int DB_CYC    = 500000
) (
  input  logic         CLOCK_50,
  input  logic         reset,
  seq_player_if.master bus
);

  localparam int            TW        = $clog2(TICK_DIV + 1);
  localparam int            DW        = $clog2(DB_CYC + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DB_CYC - 1);
  localparam logic [6:0]    STEP_LAST = 7'(NUM_STEPS - 1);

  typedef enum logic [1:0] {IDLE, PLAY, PAUSE} state_e;

  logic [3:0]    keys_raw;
  logic [3:0]    sync1_q, sync2_q, level_q, ev_q;
  logic [DW-1:0] db_cnt_q [4];

  state_e        state_q, state_d;
  logic [6:0]    step_q, step_d, step_inc, step_dec;
  logic [TW-1:0] tick_q, tick_d;
  logic          start_q, reload;
  logic [1:0]    load_q;
  logic [7:0]    freq_q;
  logic          valid_q, playing_q;

  assign keys_raw = {bus.KEY3, bus.KEY2, bus.KEY1, bus.KEY0};

  // Keys idle high; ev_q pulses for one cycle when a debounced level falls.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      sync1_q <= '1;
      sync2_q <= '1;
      level_q <= '1;
      ev_q    <= '0;
      for (int k = 0; k < 4; k++) db_cnt_q[k] <= '0;
    end else begin
      // NOTE: non-blocking assignments let sync1_q/sync2_q form a real two-stage chain.
      sync1_q <= keys_raw;
      sync2_q <= sync1_q;
      ev_q    <= '0;
      for (int k = 0; k < 4; k++) begin
        if (sync2_q[k] == level_q[k]) begin
          db_cnt_q[k] <= '0;
        end else if (db_cnt_q[k] == DB_LAST) begin
          db_cnt_q[k] <= '0;
          level_q[k]  <= sync2_q[k];
          ev_q[k]     <= ~sync2_q[k];
        end else begin
          db_cnt_q[k] <= db_cnt_q[k] + 1'b1;
        end
      end
    end
  end

  assign step_inc = (step_q == STEP_LAST) ? 7'd0 : step_q + 7'd1;
  assign step_dec = (step_q == 7'd0) ? STEP_LAST : step_q - 7'd1;

  // Priority: stop > play/pause > tick advance > step fwd > step back.
  always_comb begin
    // NOTE: defaults first so every path assigns every variable and no latch is inferred.
    state_d = state_q;
    step_d  = step_q;
    tick_d  = tick_q;
    if (ev_q[1]) begin
      state_d = IDLE;
      step_d  = 7'd0;
      tick_d  = '0;
    end else if (ev_q[0]) begin
      case (state_q)
        IDLE: begin
          state_d = PLAY;
          tick_d  = '0;
        end
        PLAY:    state_d = PAUSE;
        default: state_d = PLAY;
      endcase
    end else if (state_q == PLAY) begin
      if (tick_q == TICK_LAST) begin
        tick_d = '0;
        step_d = step_inc;
      end else begin
        tick_d = tick_q + 1'b1;
      end
    end else if (ev_q[2]) begin
      step_d = step_inc;
    end else if (ev_q[3]) begin
      step_d = step_dec;
    end
  end

  assign reload = start_q | ev_q[1] | (step_d != step_q);

  // load_q[0]: address presented this cycle; load_q[1]: ROM word arrives next edge.
  // A new reload cancels both stages so only the latest address ever lands.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q   <= IDLE;
      step_q    <= 7'd0;
      tick_q    <= '0;
      start_q   <= 1'b1;
      load_q    <= 2'b00;
      freq_q    <= 8'h00;
      valid_q   <= 1'b0;
      playing_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      tick_q    <= tick_d;
      start_q   <= 1'b0;
      load_q    <= {load_q[0] & ~reload, reload};
      valid_q   <= load_q[1] & ~reload;
      if (load_q[1] && !reload) freq_q <= bus.rom_data;
      playing_q <= (state_d == PLAY);
    end
  end

  assign bus.rom_addr   = step_q;
  assign bus.seq_num    = step_q;
  assign bus.freq_num   = freq_q;
  assign bus.freq_valid = valid_q;
  assign bus.playing    = playing_q;

endmodule
